dsp_seq_ctrl: RTL and testbench

- Sequencer that drives the DSP48 datapath and its BRAM pair for one vector operation per start.
- Walks BRAM0 read addresses 0..N-1 and emits per-element ALUMODE/OPMODE/INMODE control words.
- Emits the BRAM1 write strobe and write address on the same cycle as each issue; the downstream pipeline register stage aligns them with the DSP result.
- Signals busy/done to the top-level host FSM.

---
 rtl/dsp_seq_ctrl_pkg.sv | 33 +++
 rtl/dsp_seq_ctrl_if.sv | 35 +++
 rtl/dsp_seq_ctrl_mode_decode.sv | 40 ++++
 rtl/dsp_seq_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_dsp_seq_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/dsp_seq_ctrl_pkg.sv
// Shared constants for the DSP48 sequencer: BRAM address width, DSP control
// word widths, operation codes, DSP mode constants and FSM state encodings.
package dsp_seq_ctrl_pkg;

  localparam int ADDR_WIDTH    = 5;
  localparam int ALUMODE_WIDTH = 4;
  localparam int OPMODE_WIDTH  = 7;
  localparam int INMODE_WIDTH  = 5;

  typedef enum logic [1:0] {
    OP_MUL = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10,
    OP_MAC = 2'b11
  } op_e;

  // OPMODE: MUL = X/Y from multiplier, Z=0; ADDC = Z=C, X=A:B; MACC = Z=P plus multiplier
  localparam logic [OPMODE_WIDTH-1:0]  OPMODE_MUL  = 7'h05;
  localparam logic [OPMODE_WIDTH-1:0]  OPMODE_ADDC = 7'h33;
  localparam logic [OPMODE_WIDTH-1:0]  OPMODE_MACC = 7'h25;
  // ALUMODE: ADD = Z+X+Y; SUB = Z-(X+Y)
  localparam logic [ALUMODE_WIDTH-1:0] ALUMODE_ADD = 4'h0;
  localparam logic [ALUMODE_WIDTH-1:0] ALUMODE_SUB = 4'h3;
  localparam logic [INMODE_WIDTH-1:0]  INMODE_NONE = 5'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/dsp_seq_ctrl_if.sv
// Host/datapath-facing bundle of the DSP48 sequencer. The host side drives
// start/op/len; the sequencer (slave modport) drives BRAM and DSP controls.
interface dsp_seq_ctrl_if
  import dsp_seq_ctrl_pkg::*;
#(
  parameter int PERF_WIDTH = 16
);

  logic                     start_i;
  logic [1:0]               op_i;
  logic [ADDR_WIDTH-1:0]    len_i;
  logic                     bram0_en_o;
  logic [ADDR_WIDTH-1:0]    bram0_addr_o;
  logic                     bram1_web_o;
  logic [ADDR_WIDTH-1:0]    bram1_w_addr_o;
  logic [ALUMODE_WIDTH-1:0] alumode_o;
  logic [OPMODE_WIDTH-1:0]  opmode_o;
  logic [INMODE_WIDTH-1:0]  inmode_o;
  logic                     busy_o;
  logic                     done_o;
  logic [PERF_WIDTH-1:0]    cycle_cnt_o;

  modport master (
    output start_i, op_i, len_i,
    input  bram0_en_o, bram0_addr_o, bram1_web_o, bram1_w_addr_o,
    input  alumode_o, opmode_o, inmode_o, busy_o, done_o, cycle_cnt_o
  );

  modport slave (
    input  start_i, op_i, len_i,
    output bram0_en_o, bram0_addr_o, bram1_web_o, bram1_w_addr_o,
    output alumode_o, opmode_o, inmode_o, busy_o, done_o, cycle_cnt_o
  );

endinterface

// File: rtl/dsp_seq_ctrl_mode_decode.sv
// Combinational per-element decode of DSP48 control words and the BRAM1
// write strobe/address from the captured operation and element index.
module dsp_mode_decode
  import dsp_seq_ctrl_pkg::*;
(
  input  op_e                      op_i,
  input  logic [ADDR_WIDTH-1:0]    idx_i,
  input  logic [ADDR_WIDTH-1:0]    len_i,
  output logic [ALUMODE_WIDTH-1:0] alumode_o,
  output logic [OPMODE_WIDTH-1:0]  opmode_o,
  output logic [INMODE_WIDTH-1:0]  inmode_o,
  output logic                     web_o,
  output logic [ADDR_WIDTH-1:0]    w_addr_o
);

  // Element-wise ops write every result in place; MAC accumulates in P and
  // writes only the final sum to address 0.
  always_comb begin
    alumode_o = ALUMODE_ADD;
    opmode_o  = OPMODE_MUL;
    inmode_o  = INMODE_NONE;
    web_o     = 1'b1;
    w_addr_o  = idx_i;
    case (op_i)
      OP_MUL: ;
      OP_ADD: opmode_o = OPMODE_ADDC;
      OP_SUB: begin
        opmode_o  = OPMODE_ADDC;
        alumode_o = ALUMODE_SUB;
      end
      OP_MAC: begin
        opmode_o = (idx_i == '0) ? OPMODE_MUL : OPMODE_MACC;
        web_o    = (idx_i == len_i);
        w_addr_o = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dsp_seq_ctrl.sv
// DSP48 vector-operation sequencer: one start walks BRAM0 addresses 0..len,
// issues per-element DSP control words and BRAM1 write strobes, drains the
// DSP pipeline, then pulses done. All outputs are registered.
// Optional feature macro: DSP_SEQ_PERF_EN builds a saturating busy-cycle
// counter on cycle_cnt_o; without it the port reads 0.
module dsp_seq_ctrl
  import dsp_seq_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int PERF_WIDTH   = 16
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  dsp_seq_ctrl_if.slave  bus
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

  state_e                   state_q, state_d;
  op_e                      op_q, op_d;
  logic [ADDR_WIDTH-1:0]    idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]    len_q, len_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic                     en_q, en_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic                     web_q, web_d;
  logic [ADDR_WIDTH-1:0]    waddr_q, waddr_d;
  logic [ALUMODE_WIDTH-1:0] alumode_q, alumode_d;
  logic [OPMODE_WIDTH-1:0]  opmode_q, opmode_d;
  logic [INMODE_WIDTH-1:0]  inmode_q, inmode_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic [ALUMODE_WIDTH-1:0] dec_alumode;
  logic [OPMODE_WIDTH-1:0]  dec_opmode;
  logic [INMODE_WIDTH-1:0]  dec_inmode;
  logic                     dec_web;
  logic [ADDR_WIDTH-1:0]    dec_waddr;

  // Decode is fed the next-cycle op/index so its result lands in the output
  // registers together with the matching BRAM0 address.
  dsp_mode_decode u_decode (
    .op_i      (op_d),
    .idx_i     (idx_d),
    .len_i     (len_d),
    .alumode_o (dec_alumode),
    .opmode_o  (dec_opmode),
    .inmode_o  (dec_inmode),
    .web_o     (dec_web),
    .w_addr_o  (dec_waddr)
  );

  // Next-state logic: capture on start, walk idx to len, count drain cycles.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          op_d    = op_e'(bus.op_i);
          len_d   = bus.len_i;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (idx_q == len_q) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          idx_d = idx_q + ADDR_WIDTH'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output values for the coming cycle; DRAIN holds the last control words
  // so DSP stages still in flight see stable modes.
  always_comb begin
    en_d      = 1'b0;
    addr_d    = '0;
    web_d     = 1'b0;
    waddr_d   = '0;
    alumode_d = '0;
    opmode_d  = '0;
    inmode_d  = '0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_d)
      ST_RUN: begin
        en_d      = 1'b1;
        addr_d    = idx_d;
        web_d     = dec_web;
        waddr_d   = dec_waddr;
        alumode_d = dec_alumode;
        opmode_d  = dec_opmode;
        inmode_d  = dec_inmode;
        busy_d    = 1'b1;
      end
      ST_DRAIN: begin
        addr_d    = addr_q;
        waddr_d   = waddr_q;
        alumode_d = alumode_q;
        opmode_d  = opmode_q;
        inmode_d  = inmode_q;
        busy_d    = 1'b1;
      end
      ST_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  // State, captured operands and registered outputs; reset aborts at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MUL;
      idx_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      en_q      <= 1'b0;
      addr_q    <= '0;
      web_q     <= 1'b0;
      waddr_q   <= '0;
      alumode_q <= '0;
      opmode_q  <= '0;
      inmode_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      en_q      <= en_d;
      addr_q    <= addr_d;
      web_q     <= web_d;
      waddr_q   <= waddr_d;
      alumode_q <= alumode_d;
      opmode_q  <= opmode_d;
      inmode_q  <= inmode_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.bram0_en_o     = en_q;
  assign bus.bram0_addr_o   = addr_q;
  assign bus.bram1_web_o    = web_q;
  assign bus.bram1_w_addr_o = waddr_q;
  assign bus.alumode_o      = alumode_q;
  assign bus.opmode_o       = opmode_q;
  assign bus.inmode_o       = inmode_q;
  assign bus.busy_o         = busy_q;
  assign bus.done_o         = done_q;

`ifdef DSP_SEQ_PERF_EN
  logic                  start_acc;
  logic [PERF_WIDTH-1:0] perf_q, perf_d;

  assign start_acc = (state_q == ST_IDLE) && bus.start_i;

  // Busy-cycle counter: cleared by an accepted start, saturates at all-ones.
  always_comb begin
    perf_d = perf_q;
    if (start_acc) begin
      perf_d = '0;
    end else if (busy_q && (perf_q != '1)) begin
      perf_d = perf_q + PERF_WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign bus.cycle_cnt_o = perf_q;
`else
  assign bus.cycle_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dsp_seq_ctrl.sv
// Directed bench for dsp_seq_ctrl: MUL/MAC/SUB sequences, ignored restarts,
// mid-operation reset and the optional cycle counter.
module tb_dsp_seq_ctrl;
  import dsp_seq_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   done_cnt = 0;
  int   base;
  int   webs;

  always #5 clk = ~clk;

  dsp_seq_ctrl_if bus ();

  dsp_seq_ctrl dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.done_o === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input op_e op, input logic [ADDR_WIDTH-1:0] len);
    start_cyc   = cyc;
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.len_i   = len;
    tick();
    bus.start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (bus.done_o !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, 32'(bus.done_o), 1);
    chk({tag, "_lat"}, cyc - start_cyc, exp_lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    bus.start_i = 1'b0;
    bus.op_i    = 2'b00;
    bus.len_i   = '0;
    tick();
    tick();
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_en", 32'(bus.bram0_en_o), 0);
    chk("rst_opmode", 32'(bus.opmode_o), 0);
    chk("rst_done", 32'(bus.done_o), 0);
    chk("rst_cnt", 32'(bus.cycle_cnt_o), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(bus.busy_o), 0);

    // MUL, len 3
    issue(OP_MUL, 5'd3);
    for (int i = 0; i < 4; i++) begin
      chk("mul_en", 32'(bus.bram0_en_o), 1);
      chk("mul_addr", 32'(bus.bram0_addr_o), i);
      chk("mul_web", 32'(bus.bram1_web_o), 1);
      chk("mul_waddr", 32'(bus.bram1_w_addr_o), i);
      chk("mul_opmode", 32'(bus.opmode_o), 'h05);
      chk("mul_alumode", 32'(bus.alumode_o), 'h0);
      chk("mul_inmode", 32'(bus.inmode_o), 'h00);
      chk("mul_busy", 32'(bus.busy_o), 1);
      tick();
    end
    chk("mul_drain_en", 32'(bus.bram0_en_o), 0);
    chk("mul_drain_web", 32'(bus.bram1_web_o), 0);
    chk("mul_drain_opmode", 32'(bus.opmode_o), 'h05);
    chk("mul_drain_busy", 32'(bus.busy_o), 1);
    wait_done("mul", 9);
    chk("mul_done_busy", 32'(bus.busy_o), 0);
    chk("mul_done_opmode", 32'(bus.opmode_o), 0);
    tick();
    chk("mul_done_pulse", 32'(bus.done_o), 0);

    // MAC, len 2
    issue(OP_MAC, 5'd2);
    chk("mac0_opmode", 32'(bus.opmode_o), 'h05);
    chk("mac0_web", 32'(bus.bram1_web_o), 0);
    tick();
    chk("mac1_opmode", 32'(bus.opmode_o), 'h25);
    chk("mac1_web", 32'(bus.bram1_web_o), 0);
    chk("mac1_addr", 32'(bus.bram0_addr_o), 1);
    tick();
    chk("mac2_opmode", 32'(bus.opmode_o), 'h25);
    chk("mac2_web", 32'(bus.bram1_web_o), 1);
    chk("mac2_waddr", 32'(bus.bram1_w_addr_o), 0);
    chk("mac2_addr", 32'(bus.bram0_addr_o), 2);
    wait_done("mac", 8);
    tick();

    // SUB, len 0
    issue(OP_SUB, 5'd0);
    chk("sub_alumode", 32'(bus.alumode_o), 'h3);
    chk("sub_opmode", 32'(bus.opmode_o), 'h33);
    chk("sub_web", 32'(bus.bram1_web_o), 1);
    chk("sub_addr", 32'(bus.bram0_addr_o), 0);
    tick();
    chk("sub_drain_en", 32'(bus.bram0_en_o), 0);
    chk("sub_drain_alumode", 32'(bus.alumode_o), 'h3);
    wait_done("sub", 6);
    tick();

    // Restart pulses during RUN and DONE are ignored
    base = done_cnt;
    issue(OP_ADD, 5'd1);
    chk("rs_opmode0", 32'(bus.opmode_o), 'h33);
    bus.start_i = 1'b1;
    bus.op_i    = OP_MUL;
    tick();
    bus.start_i = 1'b0;
    chk("rs_addr1", 32'(bus.bram0_addr_o), 1);
    chk("rs_opmode1", 32'(bus.opmode_o), 'h33);
    wait_done("rs", 7);
    bus.start_i = 1'b1;
    bus.op_i    = OP_SUB;
    bus.len_i   = 5'd0;
    tick();
    chk("rs_idle_busy", 32'(bus.busy_o), 0);
    chk("rs_idle_en", 32'(bus.bram0_en_o), 0);
    chk("rs_one_done", done_cnt, base + 1);
    start_cyc = cyc;
    tick();
    bus.start_i = 1'b0;
    chk("rs_accept_busy", 32'(bus.busy_o), 1);
    chk("rs_accept_alumode", 32'(bus.alumode_o), 'h3);
    wait_done("rs2", 6);
    tick();
    chk("rs_two_done", done_cnt, base + 2);

    // Reset in the middle of ADD, len 7
    base = done_cnt;
    issue(OP_ADD, 5'd7);
    tick();
    tick();
    chk("ar_addr2", 32'(bus.bram0_addr_o), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_en", 32'(bus.bram0_en_o), 0);
    chk("ar_web", 32'(bus.bram1_web_o), 0);
    chk("ar_busy", 32'(bus.busy_o), 0);
    chk("ar_opmode", 32'(bus.opmode_o), 0);
    chk("ar_addr", 32'(bus.bram0_addr_o), 0);
    tick();
    rst_n = 1'b1;
    webs = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.bram1_web_o === 1'b1 || bus.busy_o === 1'b1) webs++;
    end
    chk("ar_no_activity", webs, 0);
    chk("ar_no_done", done_cnt, base);

    // MUL, len 31: full address range, no wrap, cycle counter
    issue(OP_MUL, 5'd31);
    for (int i = 0; i < 32; i++) begin
      chk("full_addr", 32'(bus.bram0_addr_o), i);
      tick();
    end
    chk("full_nowrap_en", 32'(bus.bram0_en_o), 0);
    wait_done("full", 37);
`ifdef DSP_SEQ_PERF_EN
    chk("perf_done", 32'(bus.cycle_cnt_o), 36);
    repeat (3) tick();
    chk("perf_held", 32'(bus.cycle_cnt_o), 36);
`else
    chk("perf_done", 32'(bus.cycle_cnt_o), 0);
    repeat (3) tick();
    chk("perf_held", 32'(bus.cycle_cnt_o), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
